// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS-subset control unit sequencing the shared ALU, register file and memory port
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // R-type function codes this datapath can execute
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: funct_legal = 1'b1;
            default:                                       funct_legal = 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type funct; illegal functs never reach R_EXEC
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_NOR:  funct_alu = ALU_NOR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    // Next state and every datapath control, decoded from the current state
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        state       = state_q;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed alongside the read so PC advances on the same edge IR loads
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut while the opcode is decoded
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_d = S_R_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu(funct);
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // A - B compared via zero; ALUOut already holds the target from DECODE
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = (opcode == OP_BNE) ? ~zero : zero;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences the datapath immediately so an abandoned access commits nothing
        if (rst) begin
            state_d     = S_FETCH;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            pc_src      = 2'b00;
            pc_en       = 1'b0;
            instr_done  = 1'b0;
            illegal     = 1'b0;
            state       = 4'd0;
        end
    end

    // State register, the only storage in the block
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, instr_done, illegal;
    logic [3:0] state;

    mc_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [21:0] all_outs = {mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                            alu_src_a, alu_src_b, alu_control, pc_src, pc_en, instr_done,
                            illegal, state};

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] wf;
        logic [3:0] wm;
        logic [3:0] len;
        logic [2:0] alu3;
        logic [1:0] srcb3;
        logic       pcen_last;
        logic [1:0] pcsrc_last;
        logic       rw_last;
        logic       rd_last;
        logic       m2r_last;
        logic       we_last;
        logic       ill;
    } vec_t;

    typedef struct packed {
        logic [3:0] len;
        logic [2:0] alu3;
        logic [1:0] srcb3;
        logic       pcen_last;
        logic [1:0] pcsrc_last;
        logic       rw_last;
        logic       rd_last;
        logic       m2r_last;
        logic       we_last;
        logic       ill;
        logic [3:0] n_done;
        logic [3:0] n_rw;
        logic [3:0] n_pcen;
        logic [3:0] n_irw;
        logic [3:0] n_req;
        logic [3:0] n_iord;
        logic [3:0] n_we;
        logic       finished;
    } obs_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[20];
    int   nvec = 0;
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic [3:0] wf, input logic [3:0] wm, input logic [3:0] len,
                                input logic [2:0] alu3, input logic [1:0] srcb3,
                                input logic pcen, input logic [1:0] pcsrc, input logic rw,
                                input logic rd, input logic m2r, input logic we, input logic ill);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.wf = wf; v.wm = wm; v.len = len;
        v.alu3 = alu3; v.srcb3 = srcb3; v.pcen_last = pcen; v.pcsrc_last = pcsrc;
        v.rw_last = rw; v.rd_last = rd; v.m2r_last = m2r; v.we_last = we; v.ill = ill;
        return v;
    endfunction

    // Called just after a rising edge with the DUT in FETCH
    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        obs_t o;
        int   cyc;
        int   cap;
        logic is_mem;
        v = vecs[idx];
        sb.push_back(v);
        o = '0;
        cyc = 0;
        cap = 3 + int'(v.wf);
        while (!o.finished && cyc < 40) begin
            cyc++;
            mem_ready = !((cyc <= int'(v.wf)) ||
                          (cyc > int'(v.wf) + 3 && cyc <= int'(v.wf) + 3 + int'(v.wm)));
            opcode = v.op;
            funct  = v.fn;
            zero   = v.z;
            @(negedge clk);
            if (cyc == 1) chk($sformatf("v%0d_fetch_state", idx), 32'(state), 32'd0);
            o.n_done = o.n_done + 4'(instr_done);
            o.n_rw   = o.n_rw + 4'(reg_write);
            o.n_pcen = o.n_pcen + 4'(pc_en);
            o.n_irw  = o.n_irw + 4'(ir_write);
            o.n_req  = o.n_req + 4'(mem_req);
            o.n_iord = o.n_iord + 4'(iord);
            o.n_we   = o.n_we + 4'(mem_we);
            if (cyc == cap) begin
                o.alu3  = alu_control;
                o.srcb3 = alu_src_b;
            end
            if (instr_done || illegal) begin
                o.finished   = 1'b1;
                o.len        = 4'(cyc);
                o.pcen_last  = pc_en;
                o.pcsrc_last = pc_src;
                o.rw_last    = reg_write;
                o.rd_last    = reg_dst;
                o.m2r_last   = mem_to_reg;
                o.we_last    = mem_we;
                o.ill        = illegal;
                if (cyc < cap) begin
                    o.alu3  = alu_control;
                    o.srcb3 = alu_src_b;
                end
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d_completed", idx), 32'(o.finished), 32'd1);
        e = sb.pop_front();
        is_mem = (e.op == 6'b100011) || (e.op == 6'b101011);
        chk($sformatf("v%0d_len", idx),        32'(o.len),        32'(e.len));
        chk($sformatf("v%0d_alu_c3", idx),     32'(o.alu3),       32'(e.alu3));
        chk($sformatf("v%0d_srcb_c3", idx),    32'(o.srcb3),      32'(e.srcb3));
        chk($sformatf("v%0d_pc_en_last", idx), 32'(o.pcen_last),  32'(e.pcen_last));
        chk($sformatf("v%0d_pc_src_last", idx),32'(o.pcsrc_last), 32'(e.pcsrc_last));
        chk($sformatf("v%0d_rw_last", idx),    32'(o.rw_last),    32'(e.rw_last));
        chk($sformatf("v%0d_rd_last", idx),    32'(o.rd_last),    32'(e.rd_last));
        chk($sformatf("v%0d_m2r_last", idx),   32'(o.m2r_last),   32'(e.m2r_last));
        chk($sformatf("v%0d_we_last", idx),    32'(o.we_last),    32'(e.we_last));
        chk($sformatf("v%0d_illegal", idx),    32'(o.ill),        32'(e.ill));
        chk($sformatf("v%0d_n_done", idx),     32'(o.n_done),     e.ill ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_n_rw", idx),       32'(o.n_rw),       32'(e.rw_last));
        chk($sformatf("v%0d_n_pcen", idx),     32'(o.n_pcen),     32'd1 + 32'(e.pcen_last));
        chk($sformatf("v%0d_n_irw", idx),      32'(o.n_irw),      32'd1);
        chk($sformatf("v%0d_n_req", idx),      32'(o.n_req),
            32'd1 + 32'(e.wf) + (is_mem ? 32'd1 + 32'(e.wm) : 32'd0));
        chk($sformatf("v%0d_n_iord", idx),     32'(o.n_iord),
            is_mem ? 32'd1 + 32'(e.wm) : 32'd0);
        chk($sformatf("v%0d_n_we", idx),       32'(o.n_we),
            (e.op == 6'b101011) ? 32'd1 + 32'(e.wm) : 32'd0);
    endtask

    initial begin
        //           op        fn      z     wf    wm    len   alu3    srcb  pcen  pcsrc rw    rd    m2r   we    ill
        vecs[0]  = mk(6'h00, 6'h20, 1'b0, 4'd0, 4'd0, 4'd4, 3'b010, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(6'h00, 6'h22, 1'b0, 4'd0, 4'd0, 4'd4, 3'b110, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(6'h00, 6'h24, 1'b0, 4'd0, 4'd0, 4'd4, 3'b000, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(6'h00, 6'h25, 1'b0, 4'd0, 4'd0, 4'd4, 3'b001, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(6'h00, 6'h27, 1'b0, 4'd0, 4'd0, 4'd4, 3'b011, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(6'h00, 6'h2A, 1'b0, 4'd0, 4'd0, 4'd4, 3'b111, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(6'h23, 6'h00, 1'b0, 4'd0, 4'd0, 4'd5, 3'b010, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(6'h23, 6'h00, 1'b0, 4'd0, 4'd2, 4'd7, 3'b010, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(6'h2B, 6'h00, 1'b0, 4'd0, 4'd0, 4'd4, 3'b010, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(6'h2B, 6'h00, 1'b0, 4'd0, 4'd1, 4'd5, 3'b010, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(6'h04, 6'h00, 1'b1, 4'd0, 4'd0, 4'd3, 3'b110, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(6'h04, 6'h00, 1'b0, 4'd0, 4'd0, 4'd3, 3'b110, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(6'h05, 6'h00, 1'b0, 4'd0, 4'd0, 4'd3, 3'b110, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(6'h05, 6'h00, 1'b1, 4'd0, 4'd0, 4'd3, 3'b110, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(6'h02, 6'h00, 1'b0, 4'd0, 4'd0, 4'd3, 3'b010, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(6'h08, 6'h00, 1'b0, 4'd0, 4'd0, 4'd4, 3'b010, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(6'h3F, 6'h00, 1'b0, 4'd0, 4'd0, 4'd2, 3'b010, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[17] = mk(6'h00, 6'h00, 1'b0, 4'd0, 4'd0, 4'd2, 3'b010, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(6'h00, 6'h2A, 1'b0, 4'd2, 4'd0, 4'd6, 3'b111, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(6'h2B, 6'h00, 1'b0, 4'd1, 4'd2, 4'd7, 3'b010, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nvec = 20;

        // Reset, then a stalled fetch released into DECODE
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outputs_zero", 32'(all_outs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_state", i), 32'(state), 32'd0);
            chk($sformatf("stall%0d_req_pcen_irw", i), 32'({mem_req, pc_en, ir_write}), 32'b100);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1; opcode = 6'h23;
        @(negedge clk);
        chk("fetch_done_irw_pcen", 32'({ir_write, pc_en, state}), 32'b11_0000);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("after_fetch_state", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mem_addr_state", 32'(state), 32'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mem_read_wait", 32'({state, mem_req, iord, mem_we}), 32'b0011_110);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_mem_read_outputs", 32'(all_outs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", 32'({state, mem_req, reg_write, pc_en}), 32'b0000_100);
        @(posedge clk);
        #1;

        for (int i = 0; i < nvec; i++) begin
            run_vec(i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
